// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit. It sits downstream of instruction fetch and steps
// each instruction through IF/ID/EXE/MEM/WB. It drives the fetch controls
// (PCWre/PCSrc/IRWre) and the register-file, ALU and data-memory selects.
// The 3-bit state register is the only storage. All other outputs are
// decoded from the state, the latched opcode/funct and the ALU zero flag.
module mc_ctrl_fsm #(
   parameter logic [5:0] HALT_OP      = 6'b111111,
   parameter logic [1:0] LINK_REG_SEL = 2'b00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic [2:0] ALUOp,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b101
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_RS  = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   localparam logic [1:0] DST_RT = 2'b01;
   localparam logic [1:0] DST_RD = 2'b10;

   state_t st;

   logic is_r;
   logic d_add, d_sub, d_and, d_or, d_slt, d_jr;
   logic d_addi, d_ori, d_lw, d_sw, d_beq, d_bne, d_j, d_jal, d_halt;
   logic r_alu, d_ill;

   logic [2:0] alu_op;
   logic       alu_srcb;
   logic       ext_sel;

   // Instruction decode from the latched IR fields
   always_comb begin
      is_r   = (opcode == OP_RTYPE);
      d_add  = is_r && (funct == FN_ADD);
      d_sub  = is_r && (funct == FN_SUB);
      d_and  = is_r && (funct == FN_AND);
      d_or   = is_r && (funct == FN_OR);
      d_slt  = is_r && (funct == FN_SLT);
      d_jr   = is_r && (funct == FN_JR);
      d_addi = (opcode == OP_ADDI);
      d_ori  = (opcode == OP_ORI);
      d_lw   = (opcode == OP_LW);
      d_sw   = (opcode == OP_SW);
      d_beq  = (opcode == OP_BEQ);
      d_bne  = (opcode == OP_BNE);
      d_j    = (opcode == OP_J);
      d_jal  = (opcode == OP_JAL);
      d_halt = (opcode == HALT_OP);
      r_alu  = d_add | d_sub | d_and | d_or | d_slt;
      d_ill  = ~(r_alu | d_jr | d_addi | d_ori | d_lw | d_sw |
                 d_beq | d_bne | d_j | d_jal | d_halt);
   end

   // ALU controls are set up in EXE and then held through MEM and WB.
   // They are computed once here so those three states stay consistent.
   always_comb begin
      alu_op   = ALU_ADD;
      alu_srcb = d_addi | d_ori | d_lw | d_sw;
      ext_sel  = d_addi | d_lw | d_sw | d_beq | d_bne;
      if (d_sub | d_beq | d_bne) alu_op = ALU_SUB;
      else if (d_and)            alu_op = ALU_AND;
      else if (d_or | d_ori)     alu_op = ALU_OR;
      else if (d_slt)            alu_op = ALU_SLT;
   end

   // State sequencing; reset aborts whatever instruction is in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st <= S_IF;
      end else begin
         case (st)
            S_IF:   st <= S_ID;
            S_ID: begin
               if (d_j | d_jal | d_jr | d_ill) st <= S_IF;
               else if (d_halt)                st <= S_HALT;
               else                            st <= S_EXE;
            end
            S_EXE: begin
               if (d_beq | d_bne)    st <= S_IF;
               else if (d_lw | d_sw) st <= S_MEM;
               else                  st <= S_WB;
            end
            S_MEM:  st <= d_sw ? S_IF : S_WB;
            S_WB:   st <= S_IF;
            S_HALT: st <= S_HALT;
            default: st <= S_IF;
         endcase
      end
   end

   // Control outputs per state. Everything is held low while reset is
   // asserted, so an aborted instruction cannot write anything.
   always_comb begin
      PCWre     = 1'b0;
      PCSrc     = PC_SEQ;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = 3'b000;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      illegal   = 1'b0;
      if (rst) begin
         case (st)
            S_IF: begin
               IRWre    = 1'b1;
               InsMemRW = 1'b1;
            end
            S_ID: begin
               if (d_j) begin
                  PCWre = 1'b1;
                  PCSrc = PC_JMP;
               end else if (d_jal) begin
                  PCWre     = 1'b1;
                  PCSrc     = PC_JMP;
                  RegWre    = 1'b1;
                  RegDst    = LINK_REG_SEL;
                  WrRegDSrc = 1'b0;
               end else if (d_jr) begin
                  PCWre = 1'b1;
                  PCSrc = PC_RS;
               end else if (d_ill) begin
                  PCWre   = 1'b1;
                  PCSrc   = PC_SEQ;
                  illegal = 1'b1;
               end
            end
            S_EXE: begin
               ALUOp   = alu_op;
               ALUSrcB = alu_srcb;
               ExtSel  = ext_sel;
               if (d_beq) begin
                  PCWre = 1'b1;
                  PCSrc = zero ? PC_BR : PC_SEQ;
               end else if (d_bne) begin
                  PCWre = 1'b1;
                  PCSrc = zero ? PC_SEQ : PC_BR;
               end
            end
            S_MEM: begin
               ALUOp   = alu_op;
               ALUSrcB = alu_srcb;
               ExtSel  = ext_sel;
               if (d_lw) mRD = 1'b1;
               if (d_sw) begin
                  mWR   = 1'b1;
                  PCWre = 1'b1;
                  PCSrc = PC_SEQ;
               end
            end
            S_WB: begin
               ALUOp     = alu_op;
               ALUSrcB   = alu_srcb;
               ExtSel    = ext_sel;
               RegWre    = 1'b1;
               WrRegDSrc = 1'b1;
               PCWre     = 1'b1;
               PCSrc     = PC_SEQ;
               RegDst    = r_alu ? DST_RD : DST_RT;
               DBDataSrc = d_lw;
            end
            default: ;
         endcase
      end
   end

   assign state = st;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm. It runs directed and random instructions cycle by
// cycle. The expected outputs come from an instruction-centric model: each
// instruction kind has its own list of phases and per-kind controls.
module tb_mc_ctrl_fsm;

   localparam logic [5:0] HALT_OP      = 6'b111111;
   localparam logic [1:0] LINK_REG_SEL = 2'b00;

   logic       clk, rst;
   logic [5:0] opcode, funct;
   logic       zero;
   logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcB, ExtSel;
   logic       mRD, mWR, DBDataSrc, illegal;
   logic [1:0] PCSrc, RegDst;
   logic [2:0] ALUOp, state;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       pcwre;
      logic [1:0] pcsrc;
      logic       irwre;
      logic       insmem;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrsrc;
      logic       srcb;
      logic       ext;
      logic [2:0] aluop;
      logic       mrd;
      logic       mwr;
      logic       dbsrc;
      logic       ill;
      logic [2:0] st;
   } vec_t;

   typedef enum int {
      K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_JR, K_ADDI, K_ORI,
      K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL, K_HALT
   } kind_t;

   vec_t obs;
   assign obs = {PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
                 ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc, illegal, state};

   mc_ctrl_fsm #(.HALT_OP(HALT_OP), .LINK_REG_SEL(LINK_REG_SEL)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
      .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
      .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD),
      .mWR(mWR), .DBDataSrc(DBDataSrc), .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input vec_t o, input vec_t e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic chk1(input string tag, input logic o, input logic e);
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'd0)
         return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b001000};
      return op inside {6'b001000, 6'b001101, 6'b100011, 6'b101011, 6'b000100,
                        6'b000101, 6'b000010, 6'b000011, HALT_OP};
   endfunction

   task automatic encode(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
      fn = 6'($urandom_range(0, 63));
      case (k)
         K_ADD:  begin op = 6'd0; fn = 6'b100000; end
         K_SUB:  begin op = 6'd0; fn = 6'b100010; end
         K_AND:  begin op = 6'd0; fn = 6'b100100; end
         K_OR:   begin op = 6'd0; fn = 6'b100101; end
         K_SLT:  begin op = 6'd0; fn = 6'b101010; end
         K_JR:   begin op = 6'd0; fn = 6'b001000; end
         K_ADDI: op = 6'b001000;
         K_ORI:  op = 6'b001101;
         K_LW:   op = 6'b100011;
         K_SW:   op = 6'b101011;
         K_BEQ:  op = 6'b000100;
         K_BNE:  op = 6'b000101;
         K_J:    op = 6'b000010;
         K_JAL:  op = 6'b000011;
         K_HALT: op = HALT_OP;
         default: begin
            // random undecoded pattern: half R-type with a bad funct
            op = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            while (is_legal(op, fn)) fn = 6'($urandom_range(0, 63));
         end
      endcase
   endtask

   // Expected outputs for cycle 'cyc' of an instruction of kind k.
   // The instruction walks a phase list (IF, ID, then EXE/MEM/WB as its
   // class requires). The controls come from what each kind needs.
   task automatic model(input kind_t k, input int cyc, input logic z,
                        output vec_t e, output logic last);
      int seq[$];
      int s;
      bit rtype, branch, taken;
      rtype  = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
      branch = k inside {K_BEQ, K_BNE};
      seq = {0, 1};
      if (k == K_HALT) begin
         while (seq.size() <= cyc) seq.push_back(5);
      end else if (!(k inside {K_J, K_JAL, K_JR, K_ILL})) begin
         seq.push_back(2);
         if (k == K_LW)      seq = {seq, 3, 4};
         else if (k == K_SW) seq.push_back(3);
         else if (!branch)   seq.push_back(4);
      end
      s    = seq[cyc];
      last = (k != K_HALT) && (cyc == seq.size() - 1);
      e    = '0;
      e.st = 3'(s);
      if (s == 0) begin e.irwre = 1'b1; e.insmem = 1'b1; end
      if (last) begin
         e.pcwre = 1'b1;
         taken   = (k == K_BEQ && z) || (k == K_BNE && !z);
         if (k inside {K_J, K_JAL}) e.pcsrc = 2'b11;
         else if (k == K_JR)        e.pcsrc = 2'b10;
         else if (taken)            e.pcsrc = 2'b01;
      end
      if (s == 1 && k == K_JAL) begin
         e.regwre = 1'b1; e.regdst = LINK_REG_SEL; e.wrsrc = 1'b0;
      end
      if (s == 1 && k == K_ILL) e.ill = 1'b1;
      if (s >= 2 && s <= 4) begin
         case (k)
            K_SUB, K_BEQ, K_BNE: e.aluop = 3'b001;
            K_AND:               e.aluop = 3'b010;
            K_OR, K_ORI:         e.aluop = 3'b011;
            K_SLT:               e.aluop = 3'b100;
            default:             e.aluop = 3'b000;
         endcase
         e.srcb = k inside {K_ADDI, K_ORI, K_LW, K_SW};
         e.ext  = k inside {K_ADDI, K_LW, K_SW, K_BEQ, K_BNE};
      end
      if (s == 3) begin e.mrd = (k == K_LW); e.mwr = (k == K_SW); end
      if (s == 4) begin
         e.regwre = 1'b1; e.wrsrc = 1'b1;
         e.regdst = rtype ? 2'b10 : 2'b01;
         e.dbsrc  = (k == K_LW);
      end
   endtask

   // Run one instruction from IF. zmode<0 drives a random zero on each cycle.
   // abort_at>=0 pulls reset low in the middle of that cycle.
   task automatic run_instr(input kind_t k, input logic [5:0] op, input logic [5:0] fn,
                            input int zmode, input int abort_at, input int maxc);
      vec_t e;
      logic last, z;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         opcode = op; funct = fn; zero = z;
         #1;
         model(k, c, z, e, last);
         chk($sformatf("%s op=%b fn=%b cyc%0d", k.name(), op, fn, c), obs, e);
         chk1($sformatf("%s no_regwre_mwr cyc%0d", k.name(), c), obs.regwre & obs.mwr, 1'b0);
         if (c == abort_at) begin
            #1 rst = 1'b0;
            #1 chk("rst_async_all_zero", obs, '0);
            @(posedge clk);
            #1 chk("rst_held_all_zero", obs, '0);
            #1 rst = 1'b1;
            return;
         end
         if (last) return;
      end
      if (k != K_HALT) chk1($sformatf("%s cycle_budget", k.name()), 1'b0, 1'b1);
   endtask

   initial begin
      logic [5:0] op, fn;
      kind_t k;
      rst = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
      #1 chk("reset_state", obs, '0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // directed sequence
      encode(K_ADD, op, fn);  run_instr(K_ADD, op, fn, -1, -1, 8);
      encode(K_LW, op, fn);   run_instr(K_LW, op, fn, -1, -1, 8);
      encode(K_BEQ, op, fn);  run_instr(K_BEQ, op, fn, 1, -1, 8);
      run_instr(K_BEQ, op, fn, 0, -1, 8);
      encode(K_BNE, op, fn);  run_instr(K_BNE, op, fn, 1, -1, 8);
      run_instr(K_BNE, op, fn, 0, -1, 8);
      encode(K_JAL, op, fn);  run_instr(K_JAL, op, fn, -1, -1, 8);
      run_instr(K_ILL, 6'b111110, 6'b100000, -1, -1, 8);
      encode(K_SW, op, fn);   run_instr(K_SW, op, fn, -1, -1, 8);

      // reset in the middle of EXE of an add, then fetch resumes in IF
      encode(K_ADD, op, fn);  run_instr(K_ADD, op, fn, -1, 2, 8);
      encode(K_ADD, op, fn);  run_instr(K_ADD, op, fn, -1, -1, 8);

      // random instruction stream
      for (int i = 0; i < 300; i++) begin
         k = kind_t'($urandom_range(0, 14));
         encode(k, op, fn);
         run_instr(k, op, fn, -1, -1, 8);
      end

      // halt holds for 20 cycles, then reset restarts fetch
      encode(K_HALT, op, fn); run_instr(K_HALT, op, fn, -1, -1, 22);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("halt_rst_all_zero", obs, '0);
      #1 rst = 1'b1;
      encode(K_ORI, op, fn);  run_instr(K_ORI, op, fn, -1, -1, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
